// File: rtl/tiny_pkg.sv
// tiny_pkg: shared widths, command opcodes and controller states for the tiny host controller.
// No ports; imported by beat_packer and tiny_host_ctrl.
package tiny_pkg;
  localparam int ELEM_W = 198;
  localparam int ADDR_W = 6;
  localparam int BEAT_W = 33;
  localparam int BEATS = 6;
  localparam int CNT_W = 3;
  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_RUN   = 2'b10,
    OP_NOP   = 2'b11
  } op_e;
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_RADDR,
    S_SEND,
    S_RUN
  } state_e;
endpackage

// File: rtl/beat_packer.sv
// beat_packer: 6x33-bit <-> 198-bit shift register with beat counter, used for both pack and unpack.
// Ports: clk/reset (async active-low); load_i/word_i parallel load (clears counter);
// shift_i/beat_i shift one beat in at the top while the lowest beat leaves;
// word_o low OUT_W bits of the register; last_o high while the counter sits on the final beat.
module beat_packer
  import tiny_pkg::*;
#(
  parameter int OUT_W = ELEM_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [ELEM_W-1:0] word_i,
  input  logic              shift_i,
  input  logic [BEAT_W-1:0] beat_i,
  output logic [OUT_W-1:0]  word_o,
  output logic              last_o
);
  logic [ELEM_W-1:0] word_q, word_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign last_o = cnt_q == CNT_W'(BEATS - 1);
  assign word_o = word_q[OUT_W-1:0];
  // Beats enter at the top and move down, so after six shifts beat 0 sits in the lowest slice.
  always_comb begin
    word_d = load_i ? word_i : shift_i ? {beat_i, word_q[ELEM_W-1:BEAT_W]} : word_q;
    cnt_d = load_i ? '0 : shift_i ? (last_o ? '0 : cnt_q + 1'b1) : cnt_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_q <= '0;
      cnt_q <= '0;
    end else begin
      word_q <= word_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/tiny_host_ctrl.sv
// tiny_host_ctrl: host-side initiator that writes/reads 198-bit elements in the tiny core RAM
// as six 33-bit beats and launches pairing runs.
// Ports: clk, reset (async active-low); cmd_* command handshake; in_* write-beat handshake;
// out_* read-beat handshake; busy; core side sel/addr/w/data/go out, core_out/done in.
module tiny_host_ctrl
  import tiny_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BEAT_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BEAT_W-1:0] out_data,
  output logic              busy,
  output logic              sel,
  output logic [ADDR_W-1:0] addr,
  output logic              w,
  output logic [ELEM_W-1:0] data,
  output logic              go,
  input  logic [ELEM_W-1:0] core_out,
  input  logic              done
);
  localparam int LAT_W = $clog2(RD_LAT + 1);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic first_q;
  logic pack_shift, pack_last, unpack_load, unpack_shift, unpack_last;
  logic [ELEM_W-1:0] pack_word;
  assign pack_shift = state_q == S_LOAD && in_valid;
  assign unpack_load = state_q == S_RADDR && lat_q == LAT_W'(RD_LAT - 1);
  assign unpack_shift = state_q == S_SEND && out_ready;
  beat_packer #(.OUT_W(ELEM_W)) u_pack (
    .clk(clk),
    .reset(reset),
    .load_i(1'b0),
    .word_i('0),
    .shift_i(pack_shift),
    .beat_i(in_data),
    .word_o(pack_word),
    .last_o(pack_last)
  );
  // Zeros shift in behind the outgoing beats, so out_data returns to zero once the element is sent.
  beat_packer #(.OUT_W(BEAT_W)) u_unpack (
    .clk(clk),
    .reset(reset),
    .load_i(unpack_load),
    .word_i(core_out),
    .shift_i(unpack_shift),
    .beat_i('0),
    .word_o(out_data),
    .last_o(unpack_last)
  );
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    lat_d = (state_q == S_RADDR && !unpack_load) ? lat_q + 1'b1 : '0;
    cmd_ready = state_q == S_IDLE;
    in_ready = state_q == S_LOAD;
    out_valid = state_q == S_SEND;
    busy = state_q != S_IDLE;
    sel = state_q == S_WRITE || state_q == S_RADDR;
    w = state_q == S_WRITE;
    addr = sel ? addr_q : '0;
    data = w ? pack_word : '0;
    go = state_q == S_RUN && first_q;
    case (state_q)
      S_IDLE: if (cmd_valid) begin
        addr_d = cmd_addr;
        state_d = cmd_op == OP_WRITE ? S_LOAD : cmd_op == OP_READ ? S_RADDR :
                  cmd_op == OP_RUN ? S_RUN : S_IDLE;
      end
      S_LOAD: if (pack_shift && pack_last) state_d = S_WRITE;
      S_WRITE: state_d = S_IDLE;
      S_RADDR: if (unpack_load) state_d = S_SEND;
      S_SEND: if (unpack_shift && unpack_last) state_d = S_IDLE;
      // first_q masks the go cycle so a done left high from a previous run is not taken.
      S_RUN: if (!first_q && done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q <= '0;
      lat_q <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      lat_q <= lat_d;
      first_q <= state_q == S_IDLE;
    end
  end
endmodule

// File: tb/tb_tiny_host_ctrl.sv
// tb_tiny_host_ctrl: self-checking bench for tiny_host_ctrl against a RAM model and a reference memory image.
module tb_tiny_host_ctrl;
  import tiny_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [1:0] cmd_op = '0;
  logic [5:0] cmd_addr = '0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [32:0] in_data = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [32:0] out_data;
  logic busy, sel, w, go;
  logic [5:0] addr;
  logic [197:0] data, core_out;
  logic done = 1'b0;
  int checks = 0, failures = 0, cyc = 0, sel_cnt = 0, wr_cnt = 0, go_cnt = 0;
  logic [197:0] mem [64];
  logic [197:0] ref_mem [64];
  logic [197:0] noise = '0;

  always #5 clk = ~clk;

  tiny_host_ctrl #(.RD_LAT(1)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .sel(sel), .addr(addr), .w(w), .data(data), .go(go),
    .core_out(core_out), .done(done)
  );

  function automatic logic [197:0] rand_elem();
    logic [197:0] r = '0;
    for (int i = 0; i < 7; i++) r = {r[165:0], 32'($urandom())};
    return r;
  endfunction

  // RAM model: read data is valid while the read address is held, garbage at all other times.
  assign core_out = (sel && !w) ? mem[addr] : noise;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    noise <= rand_elem();
    if (sel) sel_cnt <= sel_cnt + 1;
    if (go) go_cnt <= go_cnt + 1;
    if (sel && w) begin
      wr_cnt <= wr_cnt + 1;
      mem[addr] <= data;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [197:0] obs, input logic [197:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns at the negedge of the cycle after acceptance; t is the acceptance cycle.
  task automatic send_cmd(input logic [1:0] op, input logic [5:0] a, output int t);
    int n = 0;
    cmd_op = op;
    cmd_addr = a;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_wait", 198'(n < 50), 198'(1));
    t = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom());
    cmd_addr = 6'($urandom());
  endtask

  task automatic write_elem(input logic [5:0] a, input logic [197:0] v, input bit stall);
    int t, n, w0, s0;
    s0 = sel_cnt;
    send_cmd(OP_WRITE, a, t);
    w0 = wr_cnt;
    for (int k = 0; k < 6; k++) begin
      if (stall) repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        in_data = 33'($urandom());
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data = v[33*k +: 33];
      n = 0;
      while (!in_ready && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("wr_beat_wait", 198'(n < 50), 198'(1));
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("wr_sel", 198'(sel), 198'(1));
    chk("wr_w", 198'(w), 198'(1));
    chk("wr_addr", 198'(addr), 198'(a));
    chk("wr_data", data, v);
    @(negedge clk);
    chk("wr_cmd_ready", 198'(cmd_ready), 198'(1));
    chk("wr_data_idle", data, '0);
    chk("wr_strobes", 198'(wr_cnt - w0), 198'(1));
    chk("wr_sel_cycles", 198'(sel_cnt - s0), 198'(1));
  endtask

  // mode 0: out_ready high, 1: 1-0-0-1 pattern, 2: random
  task automatic read_elem(input logic [5:0] a, input int mode);
    logic [197:0] got = '0;
    logic [32:0] held = '0;
    bit stalled = 0;
    int nb = 0, n = 0, t, tl = 0, s0, w0;
    s0 = sel_cnt;
    w0 = wr_cnt;
    out_ready = 1'b0;
    send_cmd(OP_READ, a, t);
    chk("rd_sel", 198'(sel), 198'(1));
    chk("rd_w", 198'(w), 198'(0));
    chk("rd_addr", 198'(addr), 198'(a));
    chk("rd_early_valid", 198'(out_valid), 198'(0));
    @(negedge clk);
    chk("rd_sel_end", 198'(sel), 198'(0));
    chk("rd_first_valid", 198'(out_valid), 198'(1));
    while (nb < 6 && n < 200) begin
      out_ready = mode == 0 ? 1'b1 : mode == 1 ? (n % 4 == 0 || n % 4 == 3) : 1'($urandom_range(0, 1));
      if (stalled) chk("rd_hold", 198'(out_data), 198'(held));
      if (out_valid && out_ready) begin
        got[33*nb +: 33] = out_data;
        chk("rd_beat", 198'(out_data), 198'(ref_mem[a][33*nb +: 33]));
        nb++;
        tl = cyc;
        stalled = 0;
      end else if (out_valid) begin
        stalled = 1;
        held = out_data;
      end
      @(negedge clk);
      n++;
    end
    out_ready = 1'b0;
    chk("rd_beats", 198'(nb), 198'(6));
    chk("rd_elem", got, ref_mem[a]);
    chk("rd_back_idle", 198'(cmd_ready), 198'(1));
    chk("rd_valid_off", 198'(out_valid), 198'(0));
    if (mode == 0) chk("rd_latency", 198'(tl - t), 198'(7));
    chk("rd_sel_cycles", 198'(sel_cnt - s0), 198'(1));
    chk("rd_no_write", 198'(wr_cnt - w0), 198'(0));
  endtask

  initial begin
    logic [197:0] v0, v1, v2, v;
    logic [5:0] a;
    int t, tg, s0, g0, w0;
    int q[$];
    v0 = 198'h115a25886512165251569195908560596a6695612620504191;
    v1 = 198'h1559546442405a181195655549614540592955a15a26984015;
    v2 = 198'h12222222222222222222222222222222222222222222222222;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", 198'(cmd_ready), 198'(1));
    chk("rst_in_ready", 198'(in_ready), 198'(0));
    chk("rst_out_valid", 198'(out_valid), 198'(0));
    chk("rst_busy", 198'(busy), 198'(0));
    chk("rst_sel", 198'(sel), 198'(0));
    chk("rst_w", 198'(w), 198'(0));
    chk("rst_go", 198'(go), 198'(0));
    chk("rst_addr", 198'(addr), 198'(0));
    chk("rst_data", data, '0);
    chk("rst_out_data", 198'(out_data), 198'(0));
    reset = 1'b1;
    @(negedge clk);

    write_elem(6'd0, v0, 1'b0);
    ref_mem[0] = v0;
    write_elem(6'd3, v1, 1'b0);
    ref_mem[3] = v1;
    read_elem(6'd0, 0);
    read_elem(6'd3, 0);
    read_elem(6'd0, 1);

    // RUN with a stale done at command time, then done 20 cycles after go
    g0 = go_cnt;
    s0 = sel_cnt;
    done = 1'b1;
    send_cmd(OP_RUN, 6'($urandom()), t);
    chk("run_go", 198'(go), 198'(1));
    chk("run_sel", 198'(sel), 198'(0));
    chk("run_busy", 198'(busy), 198'(1));
    tg = cyc;
    @(negedge clk);
    done = 1'b0;
    chk("run_go_once", 198'(go), 198'(0));
    chk("run_stale_done", 198'(busy), 198'(1));
    while (cyc - tg < 20) @(negedge clk);
    chk("run_wait", 198'(cmd_ready), 198'(0));
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    chk("run_back_idle", 198'(cmd_ready), 198'(1));
    chk("run_go_count", 198'(go_cnt - g0), 198'(1));
    chk("run_no_sel", 198'(sel_cnt - s0), 198'(0));

    // reset after beat 3 of a write: partial element discarded
    w0 = wr_cnt;
    send_cmd(OP_WRITE, 6'd5, t);
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data = 33'($urandom());
      chk("part_in_ready", 198'(in_ready), 198'(1));
      @(negedge clk);
    end
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", 198'(busy), 198'(0));
    chk("mid_rst_ready", 198'(cmd_ready), 198'(1));
    chk("mid_rst_sel", 198'(sel), 198'(0));
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_rst_no_write", 198'(wr_cnt - w0), 198'(0));
    write_elem(6'd3, v2, 1'b0);
    ref_mem[3] = v2;
    read_elem(6'd3, 0);

    // op 11 back-to-back with a write and a read
    s0 = sel_cnt;
    g0 = go_cnt;
    w0 = wr_cnt;
    send_cmd(OP_NOP, 6'd7, t);
    chk("nop_ready", 198'(cmd_ready), 198'(1));
    chk("nop_busy", 198'(busy), 198'(0));
    chk("nop_sel", 198'(sel_cnt - s0), 198'(0));
    chk("nop_go", 198'(go_cnt - g0), 198'(0));
    chk("nop_write", 198'(wr_cnt - w0), 198'(0));
    v = rand_elem();
    write_elem(6'd9, v, 1'b0);
    ref_mem[9] = v;
    read_elem(6'd9, 0);

    // randomized writes/reads with host stalls
    q = '{0, 3, 9};
    repeat (8) begin
      a = 6'($urandom());
      v = rand_elem();
      if ($urandom_range(0, 1) == 1) begin
        s0 = sel_cnt;
        send_cmd(OP_NOP, 6'($urandom()), t);
        chk("rnd_nop_idle", 198'(cmd_ready), 198'(1));
        chk("rnd_nop_sel", 198'(sel_cnt - s0), 198'(0));
      end
      write_elem(a, v, 1'b1);
      ref_mem[a] = v;
      q.push_back(int'(a));
      read_elem(6'(q[$urandom_range(0, q.size() - 1)]), 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tiny_host_ctrl.md
# tiny_host_ctrl

Host-side initiator for the `tiny` pairing core's operand RAM port (`sel`/`addr`/`w`/`data`/`out`/`done`). Accepts commands and 33-bit data beats from a narrow host bus (UART/SPI bridge or soft CPU). Packs six beats into a 198-bit GF(3^m) element and writes it into core RAM. Reads elements back and serialises them, and launches a pairing run, holding until `done`.

## Interface

Parameters:
- `RD_LAT`, 1: core cycles from `addr` (with `sel=1`, `w=0`) to valid `out`.
- `BEATS`, 6: beats per element (`BEATS*33 = 198`; fixed, not for override).

Ports:
- `clk` in 1: single clock for host and core sides.
- `reset` in 1: asynchronous, active-low.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command accepted when both high.
- `cmd_op` in 2: 00 WRITE, 01 READ, 10 RUN, 11 reserved (accepted, no-op).
- `cmd_addr` in 6: RAM word address.
- `in_valid` / `in_ready` in/out 1: write-beat handshake.
- `in_data` in 33: write beat, least-significant beat first.
- `out_valid` / `out_ready` out/in 1: read-beat handshake.
- `out_data` out 33: read beat, least-significant beat first.
- `busy` out 1: high in any state other than IDLE.
- `sel` out 1: core RAM owned by host when high.
- `addr` out 6: core RAM address.
- `w` out 1: core RAM write enable.
- `data` out 198: core RAM write data.
- `go` out 1: one-cycle pulse that starts a core run.
- `core_out` in 198: core RAM read data.
- `done` in 1: core run complete (level).

## Operation

- States: IDLE, LOAD, WRITE, RADDR, SEND, RUN.
- IDLE
  - `cmd_ready=1`; all other outputs low or zero.
  - On handshake, latch `cmd_addr`. WRITE goes to LOAD, READ to RADDR, RUN to RUN. Op 11 stays in IDLE.
- LOAD
  - `in_ready=1`.
  - Each accepted beat k (0..5) goes into `data[33k+32:33k]` of a shift/pack register; a 3-bit beat counter tracks position.
  - After beat 5, go to WRITE.
- WRITE
  - One cycle with `sel=1`, `w=1`, `addr`=latched address, `data`=packed word. Then IDLE.
- RADDR
  - `sel=1`, `w=0`, `addr` held for `RD_LAT` cycles.
  - `core_out` is captured into an unpack register on the last cycle. Then SEND.
- SEND
  - `out_valid=1`; `out_data`=beat k.
  - Advance k on `out_ready`. After beat 5 is accepted, go to IDLE.
  - `out_data` is stable while `out_valid && !out_ready`.
- RUN
  - `sel=0`, `w=0`; `go` pulses on the first RUN cycle only.
  - Wait for `done` high, sampled from the second RUN cycle on, so a stale `done` is ignored. Then IDLE.
- Outside WRITE, `w=0`. Outside WRITE and RADDR, `sel=0`.
- `data` output is driven to zero outside WRITE.
- Reset mid-operation: immediate return to IDLE. Counters and pack/unpack registers are cleared; a partial element is discarded with no RAM write.
- Host may deassert `in_valid` or `out_ready` arbitrarily; stalls have no timeout.

## Timing

- Reset values:
  - `cmd_ready=1` (IDLE).
  - `in_ready`, `out_valid`, `busy`, `sel`, `w`, `go` all 0.
  - `addr`, `data`, `out_data` all 0.
- WRITE: last beat accepted in cycle t; core write strobe (`sel=w=1`) in t+1; `cmd_ready` is high in t+2.
- READ: command accepted in t; `sel=1` in t+1..t+RD_LAT; `out_valid` first high in t+RD_LAT+1. With `out_ready` tied high, the element completes at t+RD_LAT+6.
- RUN: command in t; `go` in t+1; `done` observed in cycle d ≥ t+2; `cmd_ready` high in d+1.
- All outputs are registered; no combinational path from host inputs to core outputs.

## Structure

- Shared package `tiny_pkg`:
  - `ELEM_W=198`, `ADDR_W=6`, `BEAT_W=33`, `BEATS=6`.
  - Command op encodings.
  - State enum.
- One natural sub-module: `beat_packer`, the 6×33 ↔ 198 shift register with beat counter. It is used twice, for pack and unpack directions. The FSM stays in the top level.

## Test plan

- WRITE addr 0 with 198'h115a25886512165251569195908560596a6695612620504191 as six LSB-first beats, then WRITE addr 3 with 198'h1559546442405a181195655549614540592955a15a26984015 → exactly one `sel=w=1` cycle per command, with matching `addr`/`data`.
- READ addr 0, then addr 3, against a 1-cycle-latency RAM model → beats reassemble to exactly the values written. `sel=1` lasts one cycle and `w=0` throughout.
- READ with `out_ready` toggled 1-0-0-1 per cycle → `out_data` is held during stalls, exactly six beats, with no duplicates or drops.
- RUN with `done` already high at command time, then asserted 20 cycles after `go` → single `go` pulse; return to IDLE 21 cycles after `go`, not immediately.
- `reset` asserted after beat 3 of a WRITE → no write strobe ever occurs. The next WRITE of 198'h12222222222222222222222222222222222222222222222222 to addr 3 lands intact.
- Op 11 and back-to-back commands → op 11 produces no core activity. `cmd_ready` is reasserted per the timing above.
